// File: rtl/mask_accum16.sv
// mask_accum16: AND-accumulates a burst of 16-bit words and returns the result and word count.
// Optional build macro MASK_ACCUM16_POPCOUNT_EN adds out_ones, the set-bit count of out_data.
module mask_accum16 #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [LEN_W-1:0] out_count,
`ifdef MASK_ACCUM16_POPCOUNT_EN
  output logic [4:0]       out_ones,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [15:0]      acc, acc_n;
  logic [LEN_W-1:0] remaining, remaining_n;
  logic [LEN_W-1:0] count, count_n;

  // NOTE: state and datapath registers are cleared by the async reset so that
  // every output derived from them reads 0 while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      count     <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the
      // same pre-edge values, independent of statement order.
      state     <= state_n;
      acc       <= acc_n;
      remaining <= remaining_n;
      count     <= count_n;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_n     = state;
    acc_n       = acc;
    remaining_n = remaining;
    count_n     = count;
    in_ready    = 1'b0;
    out_valid   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          acc_n       = 16'hFFFF;
          remaining_n = len;
          count_n     = '0;
          state_n     = (len == '0) ? DONE : ACC;
        end
      end

      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_n       = acc & in_data;
          remaining_n = remaining - LEN_W'(1);
          count_n     = count + LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            state_n = DONE;
          end
        end
      end

      DONE: begin
        out_valid = 1'b1;
        // A start arriving with the handshake is deliberately not looked at here.
        if (out_ready) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign out_data  = out_valid ? acc : 16'h0000;
  assign out_count = out_valid ? count : '0;

`ifdef MASK_ACCUM16_POPCOUNT_EN
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  // out_data is already zero when not valid, so its popcount is zero too.
  assign out_ones = popcount16(out_data);
`endif

endmodule

// File: tb/tb_mask_accum16.sv
// tb_mask_accum16: randomized and directed bursts against a queue-based reference model.
// A monitor process compares every presented result with the scoreboard queue.
module tb_mask_accum16;

  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic [LEN_W-1:0] out_count;
  logic             busy;
`ifdef MASK_ACCUM16_POPCOUNT_EN
  logic [4:0]       out_ones;
`endif

  mask_accum16 #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
`ifdef MASK_ACCUM16_POPCOUNT_EN
    .out_ones  (out_ones),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      data;
    logic [LEN_W-1:0] count;
    int               ones;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] words[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expected result.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        check("out_data", 32'(out_data), 32'(exp_q[0].data));
        check("out_count", 32'(out_count), 32'(exp_q[0].count));
`ifdef MASK_ACCUM16_POPCOUNT_EN
        check("out_ones", 32'(out_ones), 32'(exp_q[0].ones));
`endif
        if (out_ready) void'(exp_q.pop_front());
      end
    end else begin
      check("idle_outputs_zero", {out_data, 8'(out_count), 8'd0}, 32'd0);
`ifdef MASK_ACCUM16_POPCOUNT_EN
      check("idle_ones_zero", 32'(out_ones), 32'd0);
`endif
    end
  end

  // Runs one burst over the contents of words[]. gap < 0 picks random gaps of 0..3
  // cycles; hold is the number of cycles the result is back-pressured.
  task automatic burst(input int gap, input int hold);
    exp_t e;
    int   n;
    n = words.size();
    e.data = 16'hFFFF;
    foreach (words[i]) e.data = e.data & words[i];
    e.count = LEN_W'(n);
    e.ones  = $countones(e.data);

    out_ready = (hold == 0);
    start     = 1'b1;
    len       = LEN_W'(n);
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);

    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(3, 0)) : ((i > 0) ? gap : 0);
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        start    = 1'($urandom_range(1, 0));
        len      = LEN_W'($urandom);
        @(posedge clk); #1;
      end
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = words[i];
      check("in_ready_acc", 32'(in_ready), 32'd1);
      if (i == n - 1) begin
        @(negedge clk);
        check("early_valid", 32'(out_valid), 32'd0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 16'($urandom);
    end

    check("valid_latency", 32'(out_valid), 32'd1);
    check("in_ready_done", 32'(in_ready), 32'd0);

    repeat (hold) begin
      start = 1'b1;
      len   = LEN_W'($urandom);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    start     = (hold > 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("idle_after_handshake", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("start_with_handshake_ignored", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #3;
    check("reset_outputs", {in_ready, out_valid, busy, out_data, 8'(out_count), 5'd0}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", {busy, in_ready, out_valid}, 32'd0);

    // Basic three-word burst, back to back.
    words = '{16'hFF0F, 16'h0FFF, 16'hF3FF};
    burst(0, 0);

    // Zero-length burst.
    words = '{};
    burst(0, 0);

    // Two words separated by a five-cycle bubble.
    words = '{16'h00FF, 16'h0F0F};
    burst(5, 0);

    // Result back-pressured for four cycles with start pulsed meanwhile.
    words = '{16'hA5F0, 16'hF0FF};
    burst(0, 4);

    // Reset after one of three words.
    start = 1'b1;
    len   = LEN_W'(3);
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h00F0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {in_ready, out_valid, busy, out_data, 8'(out_count), 5'd0}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_midburst_reset", {busy, out_valid}, 32'd0);
    words = '{16'h1234};
    burst(0, 0);

    // Maximum-length burst.
    words = '{};
    for (int i = 0; i < 255; i++) words.push_back(16'hFFFF);
    burst(0, 0);

    // Randomized bursts.
    for (int t = 0; t < 25; t++) begin
      int n;
      n = $urandom_range(12, 0);
      words = '{};
      for (int i = 0; i < n; i++) words.push_back(16'($urandom | $urandom | $urandom));
      burst(-1, int'($urandom_range(3, 0)));
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
